// File: rtl/cdb_arbiter_pkg.sv
// Shared types and sizing for the Common Data Bus arbiter: holding-buffer entry,
// broadcast packet and the modular ROB-distance helpers used for age and squash.
package cdb_arbiter_pkg;

  localparam int NUM_FU  = 5;
  localparam int NUM_ROB = 32;
  localparam int NUM_PR  = 64;
  localparam int DATA_W  = 64;
  localparam int RW      = $clog2(NUM_ROB);
  localparam int TW      = $clog2(NUM_PR);
  localparam int FW      = $clog2(NUM_FU);
  localparam int AREG_W  = 5;

  typedef struct packed {
    logic              valid;
    logic [RW-1:0]     ROB_idx;
    logic [TW-1:0]     T_idx;
    logic [AREG_W-1:0] dest_idx;
    logic [DATA_W-1:0] result;
    logic              take_branch;
  } CDB_ARB_ENTRY_t;

  typedef struct packed {
    logic              valid;
    logic [FW-1:0]     fu_idx;
    logic [RW-1:0]     ROB_idx;
    logic [TW-1:0]     T_idx;
    logic [AREG_W-1:0] dest_idx;
    logic [DATA_W-1:0] result;
    logic              take_branch;
  } CDB_PACKET_t;

  localparam CDB_ARB_ENTRY_t CDB_ARB_ENTRY_RESET = '{
    valid:       1'b0,
    ROB_idx:     {RW{1'b0}},
    T_idx:       {TW{1'b0}},
    dest_idx:    {AREG_W{1'b0}},
    result:      {DATA_W{1'b0}},
    take_branch: 1'b0
  };

  // Distance from b forward to a around the ROB ring (RW-bit wrap).
  function automatic logic [RW-1:0] rob_dist(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return a - b;
  endfunction

  // True when idx sits at or after the mispredicted branch and before the tail.
  function automatic logic in_rollback(input logic active, input logic [RW-1:0] idx,
                                       input logic [RW-1:0] rb_idx, input logic [RW-1:0] diff);
    return active && (diff >= rob_dist(idx, rb_idx));
  endfunction

endpackage

// File: rtl/cdb_arbiter_select.sv
// Combinational oldest-first selector: a binary tree of compare-min nodes over
// ROB ages; ties resolve towards the lower requester index.
module rob_age_select #(
  parameter int N  = 5,
  parameter int AW = 5,
  localparam int IW = (N > 1) ? $clog2(N) : 1,
  localparam int P  = 1 << IW
) (
  input  logic [N-1:0]         valid,
  input  logic [N-1:0][AW-1:0] age,
  output logic [N-1:0]         grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 any_valid
);

  logic [P-1:0]         valid_pad_s;
  logic [P-1:0][AW-1:0] age_pad_s;
  logic                 node_valid_s [1:2*P-1];
  logic [AW-1:0]        node_age_s   [1:2*P-1];
  logic [IW-1:0]        node_idx_s   [1:2*P-1];

  assign valid_pad_s = P'(valid);
  assign age_pad_s   = (P*AW)'(age);

  // Heap-ordered tree: leaves at P..2P-1, each parent keeps the older child.
  always_comb begin
    logic left_wins;
    left_wins = 1'b0;
    for (int i = 0; i < P; i++) begin
      node_valid_s[P+i] = valid_pad_s[i];
      node_age_s[P+i]   = age_pad_s[i];
      node_idx_s[P+i]   = IW'(i);
    end
    for (int k = P - 1; k >= 1; k--) begin
      left_wins = node_valid_s[2*k] &&
                  (!node_valid_s[2*k+1] || (node_age_s[2*k] <= node_age_s[2*k+1]));
      node_valid_s[k] = node_valid_s[2*k] || node_valid_s[2*k+1];
      node_age_s[k]   = left_wins ? node_age_s[2*k] : node_age_s[2*k+1];
      node_idx_s[k]   = left_wins ? node_idx_s[2*k] : node_idx_s[2*k+1];
    end
  end

  // Root index expanded to a one-hot grant.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      grant[i] = node_valid_s[1] && (node_idx_s[1] == IW'(i));
    end
  end

  assign grant_idx = node_idx_s[1];
  assign any_valid = node_valid_s[1];

endmodule

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: one holding buffer per FU, oldest-ROB-age grant,
// back-pressure to waiting FUs and rollback squash of buffered/incoming results.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
(
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           en,
  input  logic                           rollback_en,
  input  logic [RW-1:0]                  ROB_rollback_idx,
  input  logic [RW-1:0]                  diff_ROB,
  input  logic [RW-1:0]                  ROB_head_idx,
  input  logic [NUM_FU-1:0]              FU_done,
  input  logic [NUM_FU-1:0][RW-1:0]      FU_ROB_idx,
  input  logic [NUM_FU-1:0][TW-1:0]      FU_T_idx,
  input  logic [NUM_FU-1:0][AREG_W-1:0]  FU_dest_idx,
  input  logic [NUM_FU-1:0][DATA_W-1:0]  FU_result,
  input  logic [NUM_FU-1:0]              FU_take_branch,
  output logic [NUM_FU-1:0]              FU_stall,
  output logic                           CDB_valid,
  output logic [FW-1:0]                  CDB_fu_idx,
  output logic [RW-1:0]                  CDB_ROB_idx,
  output logic [TW-1:0]                  CDB_T_idx,
  output logic [AREG_W-1:0]              CDB_dest_idx,
  output logic [DATA_W-1:0]              CDB_result,
  output logic                           CDB_take_branch
);

  CDB_ARB_ENTRY_t            buf_r [NUM_FU];
  CDB_ARB_ENTRY_t            sel_s;
  CDB_PACKET_t               cdb_s;
  logic [NUM_FU-1:0][RW-1:0] age_s;
  logic [NUM_FU-1:0]         squash_s, in_squash_s, eligible_s;
  logic [NUM_FU-1:0]         grant_s, win_s, stall_s, load_s;
  logic [FW-1:0]             grant_idx_s;
  logic                      any_s, cdb_valid_s, rb_active_s;

  // Rollback is only honoured while the pipeline advances.
  assign rb_active_s = en && rollback_en;

  // Per-FU age, squash and eligibility.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      age_s[i]       = rob_dist(buf_r[i].ROB_idx, ROB_head_idx);
      squash_s[i]    = buf_r[i].valid &&
                       in_rollback(rb_active_s, buf_r[i].ROB_idx, ROB_rollback_idx, diff_ROB);
      in_squash_s[i] = in_rollback(rb_active_s, FU_ROB_idx[i], ROB_rollback_idx, diff_ROB);
      eligible_s[i]  = buf_r[i].valid && !squash_s[i];
    end
  end

  rob_age_select #(.N(NUM_FU), .AW(RW)) u_select (
    .valid     (eligible_s),
    .age       (age_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_valid (any_s)
  );

  assign cdb_valid_s = en && !reset && any_s;
  assign win_s       = grant_s & {NUM_FU{cdb_valid_s}};

  // A granted or squashed buffer frees its slot this cycle, so the FU may refill it.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      stall_s[i] = !reset && buf_r[i].valid && !win_s[i] && !squash_s[i];
      load_s[i]  = en && FU_done[i] && !stall_s[i] && !in_squash_s[i];
    end
  end

  // AND-OR payload mux; zero when nothing is granted.
  always_comb begin
    sel_s = CDB_ARB_ENTRY_RESET;
    for (int i = 0; i < NUM_FU; i++) begin
      sel_s = CDB_ARB_ENTRY_t'(sel_s | (buf_r[i] & {$bits(CDB_ARB_ENTRY_t){win_s[i]}}));
    end
    cdb_s.valid       = cdb_valid_s;
    cdb_s.fu_idx      = cdb_valid_s ? grant_idx_s : {FW{1'b0}};
    cdb_s.ROB_idx     = sel_s.ROB_idx;
    cdb_s.T_idx       = sel_s.T_idx;
    cdb_s.dest_idx    = sel_s.dest_idx;
    cdb_s.result      = sel_s.result;
    cdb_s.take_branch = sel_s.take_branch;
  end

  // Holding buffers: reload beats clear so a granted FU can stream one result per cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_FU; i++) begin
        buf_r[i] <= CDB_ARB_ENTRY_RESET;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (load_s[i]) begin
          buf_r[i] <= '{valid:       1'b1,
                        ROB_idx:     FU_ROB_idx[i],
                        T_idx:       FU_T_idx[i],
                        dest_idx:    FU_dest_idx[i],
                        result:      FU_result[i],
                        take_branch: FU_take_branch[i]};
        end else if (win_s[i] || squash_s[i]) begin
          buf_r[i] <= CDB_ARB_ENTRY_RESET;
        end else begin
          buf_r[i] <= buf_r[i];
        end
      end
    end
  end

  assign FU_stall        = stall_s;
  assign CDB_valid       = cdb_s.valid;
  assign CDB_fu_idx      = cdb_s.fu_idx;
  assign CDB_ROB_idx     = cdb_s.ROB_idx;
  assign CDB_T_idx       = cdb_s.T_idx;
  assign CDB_dest_idx    = cdb_s.dest_idx;
  assign CDB_result      = cdb_s.result;
  assign CDB_take_branch = cdb_s.take_branch;

endmodule
